// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch and load/store.
// Data has priority; a bounded data burst guarantees fetch progress.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              pipe_stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned BURST_W = $clog2(MAX_D_BURST + 1);
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t              state, state_n;
  logic [BURST_W-1:0]  burst_cnt, burst_n;
  logic [TMO_W-1:0]    tmo_cnt, tmo_n;
  logic                mem_req_n, mem_we_n, if_done_n, d_done_n, bus_err_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n, d_rdata_n;
  logic [31:0]         if_rdata_n;

  assign pipe_stall = (if_req & ~if_done) | (d_req & ~d_done);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      tmo_cnt   <= tmo_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      if_done   <= if_done_n;
      d_done    <= d_done_n;
      bus_err   <= bus_err_n;
    end
  end

  // Arbitration, memory handshake and completion
  always_comb begin
    state_n     = state;
    burst_n     = burst_cnt;
    tmo_n       = tmo_cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    if_done_n   = 1'b0;
    d_done_n    = 1'b0;
    bus_err_n   = bus_err;

    unique case (state)
      IDLE: begin
        // Only data grants made while a fetch is waiting count toward the burst
        if (!if_req) burst_n = '0;
        if (d_req && (!if_req || burst_cnt < BURST_W'(MAX_D_BURST))) begin
          if (if_req) burst_n = burst_cnt + BURST_W'(1);
          state_n     = BUSY_D;
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          tmo_n       = '0;
        end else if (if_req) begin
          burst_n     = '0;
          state_n     = BUSY_I;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
          tmo_n       = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          state_n   = RESP;
          if (state == BUSY_I) begin
            if_done_n  = 1'b1;
            if_rdata_n = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end else begin
            d_done_n = 1'b1;
            if (!mem_we) d_rdata_n = mem_rdata;
          end
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          // Abort: complete with zero data so the pipeline can unstall
          mem_req_n = 1'b0;
          bus_err_n = 1'b1;
          state_n   = RESP;
          if (state == BUSY_I) begin
            if_done_n  = 1'b1;
            if_rdata_n = '0;
          end else begin
            d_done_n  = 1'b1;
            d_rdata_n = '0;
          end
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: vector table plus burst, timeout and reset sequences.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata;
  logic        if_done, d_done, pipe_stall, bus_err;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_D_BURST(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .pipe_stall(pipe_stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: acks one cycle after it sees a request, when enabled
  logic [63:0] mem [0:15];
  logic        ack_en;
  logic        loaded = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      if (!loaded) begin
        for (int i = 0; i < 16; i++) mem[i] <= '0;
        mem[0] <= 64'hAAAA_BBBB_1111_2222;
        mem[1] <= 64'h0000_0000_DEAD_BEEF;
        mem[2] <= 64'h0123_4567_89AB_CDEF;
        loaded <= 1'b1;
      end
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack && ack_en) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr[6:3]];
        if (mem_we) mem[mem_addr[6:3]] <= mem_wdata;
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } grant_t;

  typedef struct {
    logic        ireq;
    logic [63:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [63:0] daddr;
    logic [63:0] dwdata;
    logic [31:0] exp_i;
    logic [63:0] exp_d;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  grant_t grant_q[$];
  logic   prev_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and log any new memory grant
  task automatic tick();
    @(negedge clk);
    if (mem_req && !prev_req) grant_q.push_back('{mem_we, mem_addr, mem_wdata});
    prev_req = mem_req;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ip, dp;
    int first, n, k;
    grant_q.delete();
    if_addr = v.iaddr; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    if_req = v.ireq; d_req = v.dreq;
    ip = v.ireq; dp = v.dreq; first = 0; n = 0;
    while ((ip || dp) && n < 60) begin
      tick(); n++;
      if (!if_done && !d_done) chk({tag, "_stall_busy"}, 64'(pipe_stall), 64'(1));
      if (if_done && ip) begin
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(v.exp_i));
        if (first == 0) first = 1;
        ip = 0; if_req = 1'b0;
      end
      if (d_done && dp) begin
        chk({tag, "_d_rdata"}, d_rdata, v.exp_d);
        if (first == 0) first = 2;
        dp = 0; d_req = 1'b0;
      end
    end
    if (ip || dp) begin
      checks++; errors++;
      $display("FAIL %s_done_wait actual=no_done required=done", tag);
    end
    tick();
    chk({tag, "_stall_after"}, 64'(pipe_stall), 64'(0));
    chk({tag, "_if_done_once"}, 64'(if_done), 64'(0));
    chk({tag, "_d_done_once"}, 64'(d_done), 64'(0));
    chk({tag, "_grant_count"}, 64'(grant_q.size()), 64'(int'(v.ireq) + int'(v.dreq)));
    if (v.ireq && v.dreq) chk({tag, "_data_first"}, 64'(first), 64'(2));
    k = 0;
    if (v.dreq && grant_q.size() > k) begin
      chk({tag, "_d_mem_we"}, 64'(grant_q[k].we), 64'(v.dwe));
      chk({tag, "_d_mem_addr"}, grant_q[k].addr, v.daddr);
      if (v.dwe) chk({tag, "_d_mem_wdata"}, grant_q[k].wdata, v.dwdata);
      k++;
    end
    if (v.ireq && grant_q.size() > k) begin
      chk({tag, "_i_mem_we"}, 64'(grant_q[k].we), 64'(0));
      chk({tag, "_i_mem_addr"}, grant_q[k].addr, v.iaddr);
    end
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    vecs[0] = '{1'b1, 64'h4,  1'b0, 1'b0, 64'h0,  64'h0,    32'hAAAA_BBBB, 64'h0};
    vecs[1] = '{1'b1, 64'h0,  1'b0, 1'b0, 64'h0,  64'h0,    32'h1111_2222, 64'h0};
    vecs[2] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h10, 64'h0,    32'h0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h8,  64'h55,   32'h0, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h8,  64'h0,    32'h0, 64'h55};
    vecs[5] = '{1'b1, 64'h4,  1'b1, 1'b0, 64'h10, 64'h0,    32'hAAAA_BBBB, 64'h0123_4567_89AB_CDEF};
    vecs[6] = '{1'b1, 64'h6,  1'b0, 1'b0, 64'h0,  64'h0,    32'hAAAA_BBBB, 64'h0};
    vecs[7] = '{1'b1, 64'h0,  1'b1, 1'b1, 64'h18, 64'hCAFE, 32'h1111_2222, 64'h0123_4567_89AB_CDEF};
    vecs[8] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h18, 64'h0,    32'h0, 64'hCAFE};

    rst = 1'b1; ack_en = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", mem_addr, 64'(0));
    chk("rst_mem_wdata", mem_wdata, 64'(0));
    chk("rst_if_done", 64'(if_done), 64'(0));
    chk("rst_d_done", 64'(d_done), 64'(0));
    chk("rst_if_rdata", 64'(if_rdata), 64'(0));
    chk("rst_d_rdata", d_rdata, 64'(0));
    chk("rst_bus_err", 64'(bus_err), 64'(0));
    chk("rst_pipe_stall", 64'(pipe_stall), 64'(0));
    rst = 1'b0; ack_en = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Starvation guard: four data grants, one fetch, then data again
    begin
      int dcnt, n;
      bit ip, dp;
      logic [5:0] exp_seq;
      grant_q.delete();
      if_addr = 64'h0; d_we = 1'b0; d_addr = 64'h10;
      if_req = 1'b1; d_req = 1'b1; ip = 1; dp = 1; dcnt = 0; n = 0;
      while ((ip || dp) && n < 200) begin
        tick(); n++;
        if (d_done && dp) begin
          dcnt++;
          if (dcnt < 5) d_addr = 64'h10 + 64'(dcnt * 8);
          else begin dp = 0; d_req = 1'b0; end
        end
        if (if_done && ip) begin ip = 0; if_req = 1'b0; end
      end
      tick();
      exp_seq = 6'b101111;
      chk("burst_grant_count", 64'(grant_q.size()), 64'(6));
      for (int g = 0; g < 6; g++)
        if (grant_q.size() > g)
          chk($sformatf("burst_grant%0d_is_data", g), 64'(grant_q[g].addr != 64'h0), 64'(exp_seq[g]));
      chk("burst_stall_after", 64'(pipe_stall), 64'(0));
    end

    // Timeout: no ack, grant aborts after 8 busy cycles
    begin
      int cnt, n;
      bit seen;
      ack_en = 1'b0; grant_q.delete();
      d_we = 1'b0; d_addr = 64'h10; d_req = 1'b1;
      cnt = 0; n = 0; seen = 0;
      while (!seen && n < 40) begin
        tick(); n++;
        if (mem_req) cnt++;
        if (d_done) seen = 1;
      end
      chk("tmo_done_seen", 64'(seen), 64'(1));
      chk("tmo_busy_cycles", 64'(cnt), 64'(8));
      chk("tmo_mem_req_low", 64'(mem_req), 64'(0));
      chk("tmo_d_rdata_zero", d_rdata, 64'(0));
      chk("tmo_bus_err_set", 64'(bus_err), 64'(1));
      d_req = 1'b0;
      tick();
      chk("tmo_done_pulse", 64'(d_done), 64'(0));
      chk("tmo_bus_err_hold", 64'(bus_err), 64'(1));
      ack_en = 1'b1;
      v = '{1'b1, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 32'h1111_2222, 64'h0};
      run_vec(v, "post_tmo");
      chk("tmo_bus_err_sticky", 64'(bus_err), 64'(1));
    end

    // Asynchronous reset in the middle of a data grant
    begin
      int n;
      ack_en = 1'b0;
      d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'h77; d_req = 1'b1;
      n = 0;
      while (!mem_req && n < 10) begin tick(); n++; end
      chk("rstmid_granted", 64'(mem_req), 64'(1));
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("rstmid_mem_req", 64'(mem_req), 64'(0));
      chk("rstmid_bus_err", 64'(bus_err), 64'(0));
      chk("rstmid_d_done", 64'(d_done), 64'(0));
      d_req = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        chk($sformatf("rstmid_hold%0d_d_done", c), 64'(d_done), 64'(0));
        chk($sformatf("rstmid_hold%0d_mem_req", c), 64'(mem_req), 64'(0));
      end
      rst = 1'b0; ack_en = 1'b1;
      v = '{1'b1, 64'h4, 1'b0, 1'b0, 64'h0, 64'h0, 32'hAAAA_BBBB, 64'h0};
      run_vec(v, "post_rst");
      chk("post_rst_bus_err", 64'(bus_err), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
